// File: rtl/ecc_rx_decoder_pkg.sv
// Shared widths, FSM state encoding and Hamming helper functions for the serial ECC receiver.
package ecc_rx_decoder_pkg;

  localparam int PACKET_SIZE   = 11;
  localparam int FRAME_SIZE    = 15;
  localparam int SYNDROME_SIZE = 4;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SHIFT  = 2'd1,
    RX_DECODE = 2'd2,
    RX_HOLD   = 2'd3
  } rx_state_e;

  // Frame bits (p-1) whose Hamming position p has bit j set; these feed syndrome bit j.
  function automatic logic [63:0] syndrome_mask(input int j, input int frame_w);
    logic [63:0] m;
    m = 64'd0;
    for (int p = 1; p <= frame_w; p++) begin
      m = m | (64'(((p >> j) & 1)) << (p - 1));
    end
    return m;
  endfunction

  // Hamming position of packet bit k: the k-th position that is not a power of two.
  function automatic int data_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) begin
          pos = p;
        end
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc_rx_decoder_if.sv
// Serial-in / host-out bundle of the ECC receiver. err_count exists only when RX_ERR_COUNT_EN is defined.
interface ecc_rx_decoder_if import ecc_rx_decoder_pkg::*; #(
  parameter int PACKET_W = PACKET_SIZE
);

  logic                rx_bit;
  logic                rx_valid;
  logic                rx_sof;
  logic [PACKET_W-1:0] data_out;
  logic                out_valid;
  logic                out_ready;
  logic                corrected;
  logic                irq;
  logic                overrun;
`ifdef RX_ERR_COUNT_EN
  logic [7:0]          err_count;

  modport master (
    output rx_bit, rx_valid, rx_sof, out_ready,
    input  data_out, out_valid, corrected, irq, overrun, err_count
  );

  modport slave (
    input  rx_bit, rx_valid, rx_sof, out_ready,
    output data_out, out_valid, corrected, irq, overrun, err_count
  );
`else
  modport master (
    output rx_bit, rx_valid, rx_sof, out_ready,
    input  data_out, out_valid, corrected, irq, overrun
  );

  modport slave (
    input  rx_bit, rx_valid, rx_sof, out_ready,
    output data_out, out_valid, corrected, irq, overrun
  );
`endif

endinterface

// File: rtl/ecc_rx_decoder_hamming_syndrome.sv
// Combinational Hamming decode: frame -> syndrome and single-error-corrected packet.
// Parameterised so the ecc decode path can reuse it unchanged.
module hamming_syndrome import ecc_rx_decoder_pkg::*; #(
  parameter int FRAME_W  = FRAME_SIZE,
  parameter int PACKET_W = PACKET_SIZE,
  parameter int SYN_W    = SYNDROME_SIZE
) (
  input  logic [FRAME_W-1:0]  frame_i,
  output logic [SYN_W-1:0]    syndrome_o,
  output logic [PACKET_W-1:0] packet_o
);

  for (genvar j = 0; j < SYN_W; j++) begin : g_syn
    localparam logic [FRAME_W-1:0] MASK = FRAME_W'(syndrome_mask(j, FRAME_W));
    assign syndrome_o[j] = ^(frame_i & MASK);
  end

  // A data bit is inverted exactly when the syndrome points at its own position.
  for (genvar k = 0; k < PACKET_W; k++) begin : g_pkt
    localparam int POS = data_pos(k);
    assign packet_o[k] = frame_i[POS-1] ^ (syndrome_o == SYN_W'(POS));
  end

endmodule

// File: rtl/ecc_rx_decoder.sv
// Serial Hamming(15,11) receiver: deserialise, correct single-bit errors, present packet on valid/ready.
// Define RX_ERR_COUNT_EN to add the saturating corrected-frame counter (err_count).
module ecc_rx_decoder import ecc_rx_decoder_pkg::*; #(
  parameter int PACKET_W = PACKET_SIZE,
  parameter int FRAME_W  = FRAME_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  ecc_rx_decoder_if.slave bus
);

  localparam int SYN_W = $clog2(FRAME_W + 1);
  localparam int CNT_W = $clog2(FRAME_W + 1);

  rx_state_e           state_q,      state_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [FRAME_W-1:0]  shreg_q,      shreg_d;
  logic [SYN_W-1:0]    syn_q,        syn_d;
  logic [PACKET_W-1:0] pkt_q,        pkt_d;
  logic                dec_q,        dec_d;
  logic [PACKET_W-1:0] data_out_q,   data_out_d;
  logic                out_valid_q,  out_valid_d;
  logic                corrected_q,  corrected_d;
  logic                irq_q,        irq_d;
  logic                overrun_q,    overrun_d;
`ifdef RX_ERR_COUNT_EN
  logic [7:0]          err_count_q,  err_count_d;
`endif

  logic [SYN_W-1:0]    syndrome_s;
  logic [PACKET_W-1:0] packet_s;
  logic                hs_s;

  hamming_syndrome #(
    .FRAME_W  (FRAME_W),
    .PACKET_W (PACKET_W),
    .SYN_W    (SYN_W)
  ) u_syndrome (
    .frame_i    (shreg_q),
    .syndrome_o (syndrome_s),
    .packet_o   (packet_s)
  );

  assign hs_s = out_valid_q && bus.out_ready;

  // Receive FSM: frame assembly, decode capture and HOLD-time overrun detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    syn_d     = syn_q;
    pkt_d     = pkt_q;
    overrun_d = overrun_q;
    case (state_q)
      RX_IDLE: begin
        if (bus.rx_valid && bus.rx_sof) begin
          shreg_d = {shreg_q[FRAME_W-2:0], bus.rx_bit};
          cnt_d   = CNT_W'(1);
          state_d = RX_SHIFT;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_SHIFT: begin
        if (bus.rx_valid) begin
          shreg_d = {shreg_q[FRAME_W-2:0], bus.rx_bit};
          if (bus.rx_sof) begin
            cnt_d   = CNT_W'(1);
            state_d = RX_SHIFT;
          end else if (cnt_q == CNT_W'(FRAME_W - 1)) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = RX_DECODE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = RX_SHIFT;
          end
        end else begin
          state_d = RX_SHIFT;
        end
      end
      RX_DECODE: begin
        syn_d   = syndrome_s;
        pkt_d   = packet_s;
        state_d = RX_HOLD;
      end
      RX_HOLD: begin
        // Bits landing here are dropped even if the host completes the handshake this same edge.
        if (bus.rx_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (hs_s) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_HOLD;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Host-side output stage, loaded one cycle after the decode capture.
  always_comb begin
    dec_d       = (state_q == RX_DECODE);
    irq_d       = dec_q;
    data_out_d  = data_out_q;
    corrected_d = corrected_q;
    out_valid_d = out_valid_q;
    if (dec_q) begin
      data_out_d  = pkt_q;
      corrected_d = (syn_q != {SYN_W{1'b0}});
      out_valid_d = 1'b1;
    end else if (hs_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
`ifdef RX_ERR_COUNT_EN
    if (dec_q && (syn_q != {SYN_W{1'b0}}) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      shreg_q     <= {FRAME_W{1'b0}};
      syn_q       <= {SYN_W{1'b0}};
      pkt_q       <= {PACKET_W{1'b0}};
      dec_q       <= 1'b0;
      data_out_q  <= {PACKET_W{1'b0}};
      out_valid_q <= 1'b0;
      corrected_q <= 1'b0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef RX_ERR_COUNT_EN
      err_count_q <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      syn_q       <= syn_d;
      pkt_q       <= pkt_d;
      dec_q       <= dec_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      corrected_q <= corrected_d;
      irq_q       <= irq_d;
      overrun_q   <= overrun_d;
`ifdef RX_ERR_COUNT_EN
      err_count_q <= err_count_d;
`endif
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.corrected = corrected_q;
  assign bus.irq       = irq_q;
  assign bus.overrun   = overrun_q;
`ifdef RX_ERR_COUNT_EN
  assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_ecc_rx_decoder.sv
// Directed bench for ecc_rx_decoder: hand-computed Hamming(15,11) frames, restart, overrun, reset in HOLD.
// With RX_ERR_COUNT_EN defined it also checks err_count and its saturation.
module tb_ecc_rx_decoder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ecc_rx_decoder_if #(.PACKET_W(11)) bus ();

  ecc_rx_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives the first nbits of f, MSB first, sof on the first one; returns #1 after the last sampling edge.
  task automatic send_bits(input logic [14:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.rx_bit   = f[14-i];
      bus.rx_valid = 1'b1;
      bus.rx_sof   = (i == 0);
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
    bus.rx_bit   = 1'b0;
  endtask

  task automatic get_packet(input string tag, input logic [10:0] exp_data, input logic exp_corr);
    int cyc;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, " latency"}, cyc, 32'd2);
    check_eq({tag, " data"}, bus.data_out, exp_data);
    check_eq({tag, " corrected"}, bus.corrected, exp_corr);
    check_eq({tag, " irq"}, bus.irq, 1'b1);
  endtask

  task automatic ack(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, " valid drop"}, bus.out_valid, 1'b0);
    check_eq({tag, " irq pulse"}, bus.irq, 1'b0);
  endtask

  initial begin
    int cnt;
    clk           = 1'b0;
    rst_n         = 1'b0;
    n_checks      = 0;
    n_errors      = 0;
    bus.rx_bit    = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_sof    = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst data", bus.data_out, 11'h000);
    check_eq("rst valid", bus.out_valid, 1'b0);
    check_eq("rst corr", bus.corrected, 1'b0);
    check_eq("rst irq", bus.irq, 1'b0);
    check_eq("rst overrun", bus.overrun, 1'b0);
`ifdef RX_ERR_COUNT_EN
    check_eq("rst errcnt", bus.err_count, 8'h00);
`endif
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // 15'h0891: bits at p1,p5,p8,p12 -> syndrome 0, data p5=d1, p12=d7 -> 11'h082.
    send_bits(15'h0891, 15);
    get_packet("clean", 11'h082, 1'b0);
    ack("clean");

    // p6 flipped -> syndrome 6.
    send_bits(15'h08B1, 15);
    get_packet("p6err", 11'h082, 1'b1);
`ifdef RX_ERR_COUNT_EN
    check_eq("p6err errcnt", bus.err_count, 8'h01);
`endif
    ack("p6err");

    // p1 (parity) flipped -> syndrome 1, payload untouched.
    send_bits(15'h0890, 15);
    get_packet("p1err", 11'h082, 1'b1);
    ack("p1err");

    // 11'h042 (d1@p5, d6@p11) encodes to p2,p4,p5,p8,p11 -> 15'h049A.
    send_bits(15'h049A, 15);
    get_packet("clean2", 11'h042, 1'b0);
    ack("clean2");

    // p15 flipped on the MSB -> syndrome 15.
    send_bits(15'h449A, 15);
    get_packet("p15err", 11'h042, 1'b1);
`ifdef RX_ERR_COUNT_EN
    check_eq("p15err errcnt", bus.err_count, 8'h03);
`endif
    ack("p15err");

    // Partial frame of 7 bits, then a full frame restarting with sof.
    send_bits(15'h08B1, 7);
    send_bits(15'h0891, 15);
    get_packet("restart", 11'h082, 1'b0);
    ack("restart");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) cnt++;
    end
    check_eq("restart single", cnt, 32'd0);

    // Host stalls; a whole new frame arrives during HOLD and is dropped.
    bus.out_ready = 1'b0;
    send_bits(15'h049A, 15);
    get_packet("hold", 11'h042, 1'b0);
    send_bits(15'h0891, 15);
    check_eq("ovr flag", bus.overrun, 1'b1);
    check_eq("ovr valid", bus.out_valid, 1'b1);
    check_eq("ovr data", bus.data_out, 11'h042);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1 && bus.data_out === 11'h042 && bus.irq === 1'b0) cnt++;
    end
    check_eq("backpressure stable", cnt, 32'd10);

    // Asynchronous reset while holding a packet.
    rst_n = 1'b0;
    #1;
    check_eq("midrst data", bus.data_out, 11'h000);
    check_eq("midrst valid", bus.out_valid, 1'b0);
    check_eq("midrst corr", bus.corrected, 1'b0);
    check_eq("midrst overrun", bus.overrun, 1'b0);
    check_eq("midrst irq", bus.irq, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.irq !== 1'b0 || bus.out_valid !== 1'b0) cnt++;
    end
    check_eq("postrst quiet", cnt, 32'd0);

    // Handshake and sof on the same edge in HOLD: bit is an overrun, FSM returns to IDLE.
    send_bits(15'h0891, 15);
    get_packet("same", 11'h082, 1'b0);
    bus.out_ready = 1'b1;
    bus.rx_valid  = 1'b1;
    bus.rx_sof    = 1'b1;
    bus.rx_bit    = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid  = 1'b0;
    bus.rx_sof    = 1'b0;
    bus.rx_bit    = 1'b0;
    check_eq("same valid", bus.out_valid, 1'b0);
    check_eq("same overrun", bus.overrun, 1'b1);
    send_bits(15'h08B1, 15);
    get_packet("after same", 11'h082, 1'b1);
    ack("after same");

`ifdef RX_ERR_COUNT_EN
    check_eq("pre sat errcnt", bus.err_count, 8'h01);
    for (int n = 0; n < 300; n++) begin
      send_bits(15'h0890, 15);
      get_packet("sat", 11'h082, 1'b1);
      ack("sat");
    end
    check_eq("sat errcnt", bus.err_count, 8'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
